// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle NPC core sequencer (optional perf counters: CORE_SEQ_PERF_EN)
module core_seq_ctrl #(
    parameter int                XLEN        = 64,
    parameter logic [XLEN-1:0]   RESET_PC    = XLEN'(64'h8000_0000),
    parameter int                BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    input  logic              ifu_rsp_valid,
    output logic              ifu_rsp_ready,
    input  logic [31:0]       ifu_rsp_instr,
    output logic [31:0]       ir,
    output logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   next_pc,
    input  logic              dec_rf_wen,
    input  logic              dec_mem_wen,
    input  logic              dec_mem_ren,
    input  logic              dec_ebreak,
    output logic              lsu_req_valid,
    input  logic              lsu_req_ready,
    output logic              lsu_req_wen,
    input  logic              lsu_rsp_valid,
    output logic              rf_we,
    output logic              halted,
    output logic              err,
    output logic [63:0]       perf_cycle,
    output logic [63:0]       perf_instret
);

    localparam int WCW = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(BUS_TIMEOUT - 1);
    localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        S_BOOT  = 4'd0,
        S_FETCH = 4'd1,
        S_FWAIT = 4'd2,
        S_EXEC  = 4'd3,
        S_MEM   = 4'd4,
        S_MWAIT = 4'd5,
        S_WB    = 4'd6,
        S_HALT  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [WCW-1:0] wait_cnt;
    logic           bus_wait;
    logic           timeout;
    logic           pc_aligned;
    logic           retire;

    // The four bus-wait states share one counter; the cycle it sits at its
    // last value is the final chance for the handshake before ERR.
    assign bus_wait   = (state == S_FETCH) || (state == S_FWAIT) ||
                        (state == S_MEM)   || (state == S_MWAIT);
    assign timeout    = bus_wait && (wait_cnt == WAIT_LAST);
    assign pc_aligned = (next_pc[1:0] == 2'b00);

    // ebreak retires as it enters HALT; normal instructions retire in WB.
    assign retire = ((state == S_WB) && pc_aligned) ||
                    ((state == S_EXEC) && dec_ebreak);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_n;
        end
    end

    // Next-state selection; a handshake always takes priority over timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_BOOT:  state_n = S_FETCH;
            S_FETCH: begin
                if (ifu_req_ready)      state_n = S_FWAIT;
                else if (timeout)       state_n = S_ERR;
            end
            S_FWAIT: begin
                if (ifu_rsp_valid)      state_n = S_EXEC;
                else if (timeout)       state_n = S_ERR;
            end
            S_EXEC: begin
                if (dec_ebreak)                      state_n = S_HALT;
                else if (dec_mem_ren || dec_mem_wen) state_n = S_MEM;
                else                                 state_n = S_WB;
            end
            S_MEM: begin
                if (lsu_req_ready)      state_n = S_MWAIT;
                else if (timeout)       state_n = S_ERR;
            end
            S_MWAIT: begin
                if (lsu_rsp_valid)      state_n = S_WB;
                else if (timeout)       state_n = S_ERR;
            end
            S_WB: begin
                if (pc_aligned)         state_n = S_FETCH;
                else                    state_n = S_ERR;
            end
            S_HALT:  state_n = S_HALT;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // Bus wait counter: restarts on every state change, counts only while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_n != state) begin
            wait_cnt <= '0;
        end else if (bus_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Instruction register captures the fetch response only while waiting for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= NOP_INSTR;
        end else if ((state == S_FWAIT) && ifu_rsp_valid) begin
            ir <= ifu_rsp_instr;
        end
    end

    // PC advances only on a clean writeback; a misaligned target leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if ((state == S_WB) && pc_aligned) begin
            pc <= next_pc;
        end
    end

    assign ifu_req_valid = (state == S_FETCH);
    assign ifu_rsp_ready = (state == S_FWAIT);
    assign lsu_req_valid = (state == S_MEM);
    assign lsu_req_wen   = (state == S_MEM) && dec_mem_wen;
    assign rf_we         = (state == S_WB) && dec_rf_wen && pc_aligned;
    assign halted        = (state == S_HALT);
    assign err           = (state == S_ERR);

`ifdef CORE_SEQ_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    // Performance counters freeze once the core is halted or faulted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((state != S_HALT) && (state != S_ERR)) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end

    assign perf_cycle   = cycle_cnt;
    assign perf_instret = instret_cnt;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign perf_cycle    = 64'd0;
    assign perf_instret  = 64'd0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - scoreboard testbench for core_seq_ctrl
module tb_core_seq_ctrl;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr, ir;
    logic [63:0] pc, next_pc;
    logic        dec_rf_wen, dec_mem_wen, dec_mem_ren, dec_ebreak;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
    logic        rf_we, halted, err;
    logic [63:0] perf_cycle, perf_instret;

    core_seq_ctrl #(.XLEN(64), .RESET_PC(RPC), .BUS_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr), .ir(ir), .pc(pc), .next_pc(next_pc),
        .dec_rf_wen(dec_rf_wen), .dec_mem_wen(dec_mem_wen),
        .dec_mem_ren(dec_mem_ren), .dec_ebreak(dec_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_rsp_valid(lsu_rsp_valid),
        .rf_we(rf_we), .halted(halted), .err(err),
        .perf_cycle(perf_cycle), .perf_instret(perf_instret)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] fetch_q[$];
    logic        lsu_q[$];
    logic [63:0] rf_q[$];
    logic [63:0] pc_model;
    logic [63:0] instret_model;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT fires a handshake or a write.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_req_valid && ifu_req_ready) begin
                chk("fetch_expected", 64'(fetch_q.size() > 0), 64'd1);
                if (fetch_q.size() > 0) chk("fetch_pc", pc, fetch_q.pop_front());
            end
            if (lsu_req_valid && lsu_req_ready) begin
                chk("lsu_expected", 64'(lsu_q.size() > 0), 64'd1);
                if (lsu_q.size() > 0) chk("lsu_wen", 64'(lsu_req_wen), 64'(lsu_q.pop_front()));
            end
            if (rf_we) begin
                chk("rf_we_expected", 64'(rf_q.size() > 0), 64'd1);
                if (rf_q.size() > 0) chk("rf_we_pc", pc, rf_q.pop_front());
            end
        end
    end

    task automatic drop_inputs();
        ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
        dec_rf_wen = 0; dec_mem_wen = 0; dec_mem_ren = 0; dec_ebreak = 0;
    endtask

    task automatic chk_perf(input string nm);
`ifdef CORE_SEQ_PERF_EN
        chk({nm, "_instret"}, perf_instret, instret_model);
`else
        chk({nm, "_perf_cycle_zero"}, perf_cycle, 64'd0);
        chk({nm, "_perf_instret_zero"}, perf_instret, 64'd0);
`endif
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_pc"}, pc, RPC);
        chk({nm, "_ir"}, 64'(ir), 64'h13);
        chk({nm, "_valids"}, 64'({ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_req_wen, rf_we}), 64'd0);
        chk({nm, "_halt_err"}, 64'({halted, err}), 64'd0);
        chk({nm, "_perf"}, perf_cycle | perf_instret, 64'd0);
    endtask

    // Called at posedge+1 with rst high; leaves the DUT in FETCH at posedge+1.
    task automatic finish_reset(input string nm, input bit late_rsp);
        drop_inputs();
        @(posedge clk); #1;
        chk({nm, "_queues_empty"}, 64'(fetch_q.size() + lsu_q.size() + rf_q.size()), 64'd0);
        fetch_q.delete(); lsu_q.delete(); rf_q.delete();
        pc_model = RPC; instret_model = 0;
        rst = 0;
        ifu_rsp_instr = 32'hdead_beef;
        ifu_rsp_valid = late_rsp; lsu_rsp_valid = late_rsp;
        #1;
        chk({nm, "_cycle1_idle"}, 64'({ifu_req_valid, lsu_req_valid}), 64'd0);
        @(posedge clk); #1;
        ifu_rsp_valid = 0; lsu_rsp_valid = 0;
        chk({nm, "_cycle2_fetch"}, 64'(ifu_req_valid), 64'd1);
        chk({nm, "_late_rsp_ignored_ir"}, 64'(ir), 64'h13);
    endtask

    task automatic apply_reset(input string nm);
        #2; rst = 1; #1;
        chk_reset(nm);
        finish_reset(nm, 1'b0);
    endtask

    // Drives one instruction from its FETCH cycle. kind: 1 next FETCH, 2 halted, 3 err, 4 aborted.
    task automatic run_instr(input logic [31:0] instr, input bit rfw, memw, memr, ebrk,
                             input logic [63:0] npc, input int req_dly, input int rsp_dly,
                             input bit ifu_never, input bit abort_mw,
                             output int cycles, output int rf_cnt, output int rf_cyc, output int kind);
        bit fetched = 0, in_mw = 0, pend_mem = 0;
        int mem_n = 0, mw_n = 0;
        cycles = 0; rf_cnt = 0; rf_cyc = 0; kind = 0;
        dec_rf_wen = rfw; dec_mem_wen = memw; dec_mem_ren = memr; dec_ebreak = ebrk;
        next_pc = npc; ifu_rsp_instr = instr;
        for (int c = 1; c <= 400; c++) begin
            if (fetched && ifu_req_valid) begin kind = 1; cycles = c - 1; break; end
            if (halted) begin kind = 2; cycles = c; break; end
            if (err)    begin kind = 3; cycles = c; break; end
            if (abort_mw && in_mw && mw_n == 1) begin
                lsu_rsp_valid = 0; #2; rst = 1; #1;
                kind = 4; cycles = c; break;
            end
            if (pend_mem) chk("lsu_req_valid_held", 64'(lsu_req_valid), 64'd1);
            ifu_req_ready = ifu_req_valid;
            if (ifu_req_valid) fetched = 1;
            ifu_rsp_valid = !ifu_never;
            lsu_req_ready = lsu_req_valid && (mem_n >= req_dly);
            if (lsu_req_valid) mem_n++;
            pend_mem = lsu_req_valid && !lsu_req_ready;
            if (in_mw) begin
                lsu_rsp_valid = (mw_n >= rsp_dly);
                mw_n++;
            end else begin
                lsu_rsp_valid = 0;
            end
            #1;
            if (rf_we) begin rf_cnt++; rf_cyc = c; end
            if (in_mw && lsu_rsp_valid) in_mw = 0;
            if (lsu_req_valid && lsu_req_ready) begin in_mw = 1; mw_n = 0; end
            @(posedge clk); #1;
        end
        ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
    endtask

    // Pushes the expected responses, runs the instruction, checks timing and model state.
    task automatic exec_case(input string nm, input logic [31:0] instr, input bit rfw, memw, memr, ebrk,
                             input logic [63:0] npc, input int req_dly, input int rsp_dly,
                             input bit ifu_never, input bit abort_mw,
                             input int exp_kind, input int exp_cycles, input int exp_rf);
        int cycles, rf_cnt, rf_cyc, kind;
        fetch_q.push_back(pc_model);
        if (!ebrk && !ifu_never && (memw || memr)) lsu_q.push_back(memw);
        if (exp_rf == 1) rf_q.push_back(pc_model);
        run_instr(instr, rfw, memw, memr, ebrk, npc, req_dly, rsp_dly, ifu_never, abort_mw,
                  cycles, rf_cnt, rf_cyc, kind);
        chk({nm, "_end_kind"}, 64'(kind), 64'(exp_kind));
        chk({nm, "_cycles"}, 64'(cycles), 64'(exp_cycles));
        chk({nm, "_rf_we_count"}, 64'(rf_cnt), 64'(exp_rf));
        if (exp_rf == 1) chk({nm, "_rf_we_cycle"}, 64'(rf_cyc), 64'(exp_cycles));
        if (exp_kind == 1) begin pc_model = npc; instret_model++; end
        if (exp_kind == 2) instret_model++;
        if (exp_kind == 4) begin
            chk_reset({nm, "_abort"});
        end else begin
            chk({nm, "_pc"}, pc, pc_model);
            if (exp_kind != 3) chk({nm, "_ir"}, 64'(ir), 64'(instr));
            chk_perf(nm);
        end
    endtask

    task automatic idle_watch(input string nm, input int n, input bit exp_halt, input bit exp_err);
        int bad = 0;
        logic [63:0] pc0 = pc;
        logic [63:0] cyc0 = perf_cycle;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ifu_req_valid || lsu_req_valid || ifu_rsp_ready || rf_we) bad++;
            if (halted !== exp_halt || err !== exp_err) bad++;
        end
        chk({nm, "_no_bus_activity"}, 64'(bad), 64'd0);
        chk({nm, "_pc_frozen"}, pc, pc0);
        chk({nm, "_perf_cycle_frozen"}, perf_cycle, cyc0);
    endtask

    initial begin
        rst = 1;
        drop_inputs();
        ifu_rsp_instr = 0; next_pc = 0;
        pc_model = RPC; instret_model = 0;
        @(posedge clk); #1;
        chk_reset("init");
        finish_reset("init", 1'b0);

        //        name       instr          rfw mw mr eb next_pc              rq rs nv ab kind cyc rf
        exec_case("addi",    32'h0010_0093, 1, 0, 0, 0, RPC + 64'h4,       0, 0, 0, 0, 1, 4,  1);
        exec_case("load",    32'h0000_2103, 1, 0, 1, 0, RPC + 64'h8,       2, 2, 0, 0, 1, 10, 1);
        exec_case("store",   32'h0020_2023, 0, 1, 0, 0, RPC + 64'hc,       0, 0, 0, 0, 1, 6,  0);
        exec_case("rw_both", 32'h0020_2223, 0, 1, 1, 0, RPC + 64'h10,      1, 1, 0, 0, 1, 8,  0);
        exec_case("branch",  32'h1000_0063, 0, 0, 0, 0, RPC + 64'h110,     0, 0, 0, 0, 1, 4,  0);
        exec_case("ld_abrt", 32'h0000_2183, 1, 0, 1, 0, RPC + 64'h114,     0, 5, 0, 1, 4, 6,  0);
        finish_reset("abort", 1'b1);

        exec_case("misalign",32'h0010_0093, 1, 0, 0, 0, RPC + 64'h2,       0, 0, 0, 0, 3, 5,  0);
        idle_watch("err_sticky", 20, 1'b0, 1'b1);
        apply_reset("rst_in_err");

        exec_case("ftimeout",32'h0010_0093, 1, 0, 0, 0, RPC + 64'h4,       0, 0, 1, 0, 3, 257, 0);
        apply_reset("rst_after_to");

        exec_case("ebreak",  32'h0010_0073, 0, 0, 0, 1, RPC + 64'h4,       0, 0, 0, 0, 2, 4,  0);
        idle_watch("halt", 100, 1'b1, 1'b0);
        chk_perf("halt_final");

        chk("final_queues_empty", 64'(fetch_q.size() + lsu_q.size() + rf_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
